// File: rtl/memoredf_pkg.sv
// Shared definitions for the EDF packet scheduler: packet layout and FSM states.
package memoredf_pkg;

  // Packet layout, MSB first: {metadata, 4 x strobe, 4 x data}
  localparam int NB_LANES     = 4;
  localparam int META_WIDTH   = 102;
  localparam int STRB_WIDTH   = 16;
  localparam int DATA_WIDTH   = 128;
  localparam int PACKET_WIDTH = META_WIDTH + NB_LANES * STRB_WIDTH + NB_LANES * DATA_WIDTH;

  // Read/write type bit: top bit of the metadata field (1 = write)
  localparam int RW_BIT_POS   = PACKET_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    POP
  } sched_state_e;

endpackage

// File: rtl/edf_min_select.sv
// Combinational earliest-deadline selector: lowest counter among valid queues,
// ties resolved towards the lowest queue index.
module edf_min_select #(
  parameter int NB_QUEUES      = 4,
  parameter int DEADLINE_WIDTH = 16,
  localparam int IDX_W         = (NB_QUEUES > 1) ? $clog2(NB_QUEUES) : 1
) (
  input  logic [NB_QUEUES-1:0]                valid_i,
  input  logic [NB_QUEUES*DEADLINE_WIDTH-1:0] deadline_i,
  output logic [IDX_W-1:0]                    idx_o,
  output logic                                found_o
);

  logic [DEADLINE_WIDTH-1:0] best;

  // Linear scan; strict less-than keeps the first (lowest-index) minimum
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    best    = '0;
    for (int unsigned i = 0; i < NB_QUEUES; i++) begin
      if (valid_i[i] && (!found_o || deadline_i[i*DEADLINE_WIDTH +: DEADLINE_WIDTH] < best)) begin
        found_o = 1'b1;
        best    = deadline_i[i*DEADLINE_WIDTH +: DEADLINE_WIDTH];
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/edf_packet_scheduler.sv
// Earliest-deadline-first scheduler feeding one packet serializer from
// NB_QUEUES requester queues, with per-queue relative-deadline counters.
module edf_packet_scheduler
  import memoredf_pkg::*;
#(
  parameter int NB_QUEUES      = 4,
  parameter int PACKET_WIDTH   = memoredf_pkg::PACKET_WIDTH,
  parameter int DEADLINE_WIDTH = 16,
  localparam int IDX_W         = (NB_QUEUES > 1) ? $clog2(NB_QUEUES) : 1
) (
  input  logic                                M_AXI_ACLK,
  input  logic                                M_AXI_ARESET,
  input  logic [NB_QUEUES-1:0]                q_valid,
  input  logic [NB_QUEUES*PACKET_WIDTH-1:0]   q_packet,
  input  logic [NB_QUEUES*DEADLINE_WIDTH-1:0] q_deadline,
  output logic [NB_QUEUES-1:0]                q_pop,
  output logic                                INIT_AXI_TXN,
  output logic [PACKET_WIDTH-1:0]             packet_out,
  input  logic                                packetConsumed,
  output logic                                deadline_miss,
  output logic [31:0]                         miss_count
);

  localparam int DW = DEADLINE_WIDTH;
  localparam int PW = PACKET_WIDTH;

  logic [NB_QUEUES*DW-1:0] dl_q, dl_d, dl_eff;
  logic [NB_QUEUES-1:0]    vld_prev_q, pop_prev_q;

  sched_state_e            state_q;
  logic [IDX_W-1:0]        sel_q;
  logic [PW-1:0]           packet_out_q;
  logic                    init_q;
  logic [NB_QUEUES-1:0]    q_pop_q;
  logic                    miss_q;
  logic [31:0]             miss_cnt_q;

  logic [IDX_W-1:0]        sel_idx;
  logic                    sel_found;
  logic [PW-1:0]           sel_pkt;
  logic [DW-1:0]           sel_dl;
  logic [NB_QUEUES-1:0]    pop_mask;

  // A freshly presented head takes its deadline in the same cycle it appears,
  // so arbitration in that cycle already sees the loaded value rather than the
  // stale zero held while the queue was empty.
  always_comb begin
    dl_eff = '0;
    dl_d   = '0;
    for (int unsigned i = 0; i < NB_QUEUES; i++) begin
      if (q_valid[i] && (!vld_prev_q[i] || pop_prev_q[i]))
        dl_eff[i*DW +: DW] = q_deadline[i*DW +: DW];
      else
        dl_eff[i*DW +: DW] = dl_q[i*DW +: DW];
      if (q_valid[i] && (dl_eff[i*DW +: DW] != '0))
        dl_d[i*DW +: DW] = dl_eff[i*DW +: DW] - DW'(1);
    end
  end

  // Deadline counters plus the history bits that detect a new head
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      dl_q       <= '0;
      vld_prev_q <= '0;
      pop_prev_q <= '0;
    end else begin
      dl_q       <= dl_d;
      vld_prev_q <= q_valid;
      pop_prev_q <= q_pop_q;
    end
  end

  edf_min_select #(
    .NB_QUEUES      (NB_QUEUES),
    .DEADLINE_WIDTH (DEADLINE_WIDTH)
  ) u_min_select (
    .valid_i    (q_valid),
    .deadline_i (dl_eff),
    .idx_o      (sel_idx),
    .found_o    (sel_found)
  );

  // Mux the candidate packet/counter and decode the granted queue's pop bit
  always_comb begin
    sel_pkt  = '0;
    sel_dl   = '0;
    pop_mask = '0;
    for (int unsigned i = 0; i < NB_QUEUES; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_pkt = q_packet[i*PW +: PW];
        sel_dl  = dl_eff[i*DW +: DW];
      end
      pop_mask[i] = (sel_q == IDX_W'(i));
    end
  end

  // Grant / issue / wait-for-serializer / pop sequence with registered pulses
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      packet_out_q <= '0;
      init_q       <= 1'b0;
      q_pop_q      <= '0;
      miss_q       <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      init_q  <= 1'b0;
      miss_q  <= 1'b0;
      q_pop_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (sel_found && packetConsumed) begin
            sel_q        <= sel_idx;
            packet_out_q <= sel_pkt;
            init_q       <= 1'b1;
            state_q      <= ISSUE;
            if (sel_dl == '0) begin
              miss_q <= 1'b1;
              if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
          end
        end
        ISSUE:     state_q <= WAIT_BUSY;
        WAIT_BUSY: if (!packetConsumed) state_q <= WAIT_DONE;
        WAIT_DONE: begin
          if (packetConsumed) begin
            q_pop_q <= pop_mask;
            state_q <= POP;
          end
        end
        POP:       state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign q_pop         = q_pop_q;
  assign INIT_AXI_TXN  = init_q;
  assign packet_out    = packet_out_q;
  assign deadline_miss = miss_q;
  assign miss_count    = miss_cnt_q;

endmodule

// File: doc/edf_packet_scheduler.md
EDF_PACKET_SCHEDULER -- requirements
Module: edf_packet_scheduler

Interface
REQ-001 SHALL have parameter NB_QUEUES, default 4: number of requester packet queues.
REQ-002 SHALL have parameter PACKET_WIDTH, default 678: packet width, 102 metadata + 4x16 strobe + 4x128 data.
REQ-003 SHALL have parameter DEADLINE_WIDTH, default 16: relative-deadline counter width.
REQ-004 SHALL have a single clock and an asynchronous, active-high reset, with ports as follows.
- M_AXI_ACLK  in  1  sole clock; all state updates on its rising edge.
- M_AXI_ARESET  in  1  asynchronous, active-high reset.
- q_valid  in  NB_QUEUES  queue i head packet valid.
- q_packet  in  NB_QUEUES*PACKET_WIDTH  head packets; queue i at slice [i*PACKET_WIDTH +: PACKET_WIDTH].
- q_deadline  in  NB_QUEUES*DEADLINE_WIDTH  relative deadline (cycles) for each queue head.
- q_pop  out  NB_QUEUES  one-cycle pulse: head of queue i served, dequeue it.
- INIT_AXI_TXN  out  1  one-cycle start pulse to serializer.
- packet_out  out  PACKET_WIDTH  packet presented to serializer.
- packetConsumed  in  1  serializer done flag; 1 = idle/consumed.
- deadline_miss  out  1  one-cycle pulse: issued packet's counter was 0 at grant.
- miss_count  out  32  saturating count of deadline_miss pulses.

Function
REQ-005 SHALL keep per-queue counter dl[i]: load q_deadline[i] in the cycle q_valid[i] rises, or the cycle after q_pop[i] when q_valid[i] is still 1; otherwise decrement by 1 each cycle, saturating at 0.
REQ-006 SHALL hold dl[i] at 0 while q_valid[i]=0.
REQ-007 SHALL select, combinationally, the valid queue with minimum dl; ties go to the lowest index.
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, POP.
REQ-009 IDLE: if any q_valid=1 and packetConsumed=1, SHALL latch the selected index into sel_q and q_packet[sel_q] into packet_out; next state ISSUE.
REQ-010 ISSUE: SHALL assert INIT_AXI_TXN for exactly this one cycle; next state WAIT_BUSY.
REQ-011 WAIT_BUSY: SHALL wait for packetConsumed=0; next state WAIT_DONE.
REQ-012 WAIT_DONE: SHALL wait for packetConsumed=1; next state POP.
REQ-013 POP: SHALL assert q_pop[sel_q] for one cycle; next state IDLE.
REQ-014 SHALL hold packet_out stable from latch through POP, since the serializer samples it combinationally for the whole burst.
REQ-015 SHALL not re-arbitrate or change sel_q outside IDLE; queues arriving meanwhile keep counting down.
REQ-016 SHALL pulse deadline_miss in ISSUE if dl[sel_q] was 0 when latched, and increment miss_count, saturating at 2^32-1.
REQ-017 SHALL treat q_valid[sel_q] falling during WAIT_* as a protocol error: ignored, transaction still completes and q_pop still pulses.
REQ-018 Grant-to-grant minimum SHALL be 5 cycles: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, POP; INIT_AXI_TXN rises 1 cycle after the IDLE grant.

Reset
REQ-019 On M_AXI_ARESET=1, asynchronously: state=IDLE, sel_q=0, packet_out=0, INIT_AXI_TXN=0, q_pop=0, all dl=0, deadline_miss=0, miss_count=0.
REQ-020 Reset mid-transaction SHALL abandon it without q_pop; after release the FSM waits in IDLE for packetConsumed=1.

Structure
REQ-021 SHALL place the state enum, PACKET_WIDTH, metadata/strobe/data field widths and the read/write type-bit position in shared package memoredf_pkg.
REQ-022 SHALL implement the min-deadline selector as sub-module edf_min_select (parameterised NB_QUEUES, DEADLINE_WIDTH; outputs index and found flag).

Verification
REQ-023 Single request: q_valid=0001, q_deadline[0]=20 -> INIT pulse 1 cycle after grant; packet_out=q_packet[0]; after serializer done, q_pop=0001 once.
REQ-024 EDF order: queues 1,2,3 valid with deadlines 50,10,30 at once -> service order 2,3,1.
REQ-025 Tie: queues 0 and 3, both deadline 8 -> queue 0 first.
REQ-026 Miss: queue 1 deadline 2, serializer held busy 10 cycles by queue 0 -> queue 1 issues with deadline_miss=1, miss_count=1.
REQ-027 Stability: change q_packet[sel_q] during WAIT_DONE -> packet_out unchanged until POP.
REQ-028 Reset asserted in WAIT_BUSY -> all outputs 0 immediately, no q_pop; request still valid re-issues after reset release and packetConsumed=1.
